// File: rtl/dma_arbiter.sv
// Two-requester DMA burst arbiter: grants one burst at a time and issues one DMA access per cycle.
// Optional macro DMA_ARB_RR_EN selects round-robin arbitration; without it requester 0 has fixed priority.
module dma_arbiter #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned LEN_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              rw0,
  input  logic              rw1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [LEN_W-1:0]  len0,
  input  logic [LEN_W-1:0]  len1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              beat0,
  output logic              beat1,
  output logic              done0,
  output logic              done1,
  output logic              dma_enable,
  output logic              dma_rw,
  output logic [ADDR_W-1:0] dma_address,
  output logic [DATA_W-1:0] dma_input_data,
  output logic              busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_XFER = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]        state_q, state_d;
  logic              gnt_q, gnt_d;
  logic              rw_q, rw_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  idx_q, idx_d;
  logic              win;
  logic              gnt_req;
`ifdef DMA_ARB_RR_EN
  logic              last_q, last_d;
`endif

  // Next-state and output decode; outputs follow the registered state, wdata passes straight through.
  always_comb begin
    state_d        = state_q;
    gnt_d          = gnt_q;
    rw_d           = rw_q;
    addr_d         = addr_q;
    len_d          = len_q;
    idx_d          = idx_q;
`ifdef DMA_ARB_RR_EN
    last_d         = last_q;
    win            = (req0 && req1) ? ~last_q : req1;
`else
    win            = ~req0;
`endif
    gnt_req        = gnt_q ? req1 : req0;
    beat0          = 1'b0;
    beat1          = 1'b0;
    done0          = 1'b0;
    done1          = 1'b0;
    dma_enable     = 1'b0;
    dma_rw         = 1'b0;
    dma_address    = '0;
    dma_input_data = '0;
    busy           = (state_q != S_IDLE);

    case (state_q)
      S_IDLE: begin
        if (req0 || req1) begin
          gnt_d   = win;
          rw_d    = win ? rw1 : rw0;
          addr_d  = win ? addr1 : addr0;
          len_d   = win ? len1 : len0;
          idx_d   = '0;
          state_d = ((win ? len1 : len0) == '0) ? S_DONE : S_XFER;
`ifdef DMA_ARB_RR_EN
          last_d  = win;
`endif
        end
      end
      S_XFER: begin
        dma_enable     = 1'b1;
        dma_rw         = rw_q;
        dma_address    = ADDR_W'(addr_q + ADDR_W'(idx_q));
        dma_input_data = gnt_q ? wdata1 : wdata0;
        beat0          = ~gnt_q;
        beat1          = gnt_q;
        idx_d          = LEN_W'(idx_q + LEN_W'(1));
        // A dropped request still gets this beat, then the burst closes.
        if (!gnt_req || (idx_q == LEN_W'(len_q - LEN_W'(1)))) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        done0   = ~gnt_q;
        done1   = gnt_q;
        gnt_d   = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      gnt_q   <= 1'b0;
      rw_q    <= 1'b0;
      addr_q  <= '0;
      len_q   <= '0;
      idx_q   <= '0;
`ifdef DMA_ARB_RR_EN
      last_q  <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      rw_q    <= rw_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
`ifdef DMA_ARB_RR_EN
      last_q  <= last_d;
`endif
    end
  end

endmodule

// File: tb/tb_dma_arbiter.sv
// Bench for dma_arbiter: directed vector tables, corner-case sequences and random traffic
// checked cycle by cycle against a burst-level reference model.
module tb_dma_arbiter;

  typedef struct {
    logic        rst;
    logic        r0, r1, rw0, rw1;
    logic [15:0] a0, a1;
    logic [7:0]  l0, l1;
    logic [15:0] w0, w1;
  } in_t;

  // flags = {beat0, beat1, done0, done1, dma_enable, dma_rw, busy}
  typedef struct {
    in_t         i;
    logic [6:0]  flags;
    logic [15:0] addr;
    logic [15:0] data;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset, req0, req1, rw0, rw1;
  logic [15:0] addr0, addr1, wdata0, wdata1;
  logic [7:0]  len0, len1;
  logic        beat0, beat1, done0, done1, dma_enable, dma_rw, busy;
  logic [15:0] dma_address, dma_input_data;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: a burst is described by beats still owed and whether a done pulse is pending.
  bit          m_valid = 1'b0;
  int          m_left = 0;
  int          m_k = 0;
  bit          m_done_due = 1'b0;
  bit          m_owner = 1'b0;
  bit          m_last = 1'b1;
  logic        m_rw = 1'b0;
  logic [15:0] m_base = '0;

  dma_arbiter #(.ADDR_W(16), .DATA_W(16), .LEN_W(8)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .rw0(rw0), .rw1(rw1),
    .addr0(addr0), .addr1(addr1), .len0(len0), .len1(len1),
    .wdata0(wdata0), .wdata1(wdata1),
    .beat0(beat0), .beat1(beat1), .done0(done0), .done1(done1),
    .dma_enable(dma_enable), .dma_rw(dma_rw), .dma_address(dma_address),
    .dma_input_data(dma_input_data), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic in_t inp(logic r0, logic r1, logic rw0_v, logic rw1_v,
                              logic [15:0] a0, logic [15:0] a1, logic [7:0] l0, logic [7:0] l1,
                              logic [15:0] w0, logic [15:0] w1);
    in_t t;
    t.rst = 1'b0; t.r0 = r0; t.r1 = r1; t.rw0 = rw0_v; t.rw1 = rw1_v;
    t.a0 = a0; t.a1 = a1; t.l0 = l0; t.l1 = l1; t.w0 = w0; t.w1 = w1;
    return t;
  endfunction

  function automatic vec_t mkv(in_t i, logic [6:0] f, logic [15:0] a, logic [15:0] d);
    vec_t v;
    v.i = i; v.flags = f; v.addr = a; v.data = d;
    return v;
  endfunction

  function automatic logic [38:0] model_out(in_t i);
    logic [6:0]  f;
    logic [15:0] a, d;
    f = '0; a = '0; d = '0;
    if (m_left > 0) begin
      f = {~m_owner, m_owner, 2'b00, 1'b1, m_rw, 1'b1};
      a = m_base + 16'(m_k);
      d = m_owner ? i.w1 : i.w0;
    end else if (m_done_due) begin
      f = {2'b00, ~m_owner, m_owner, 3'b001};
    end
    return {f, a, d};
  endfunction

  task automatic model_step(in_t i);
    bit w;
    if (i.rst) begin
      m_left = 0; m_k = 0; m_done_due = 1'b0; m_last = 1'b1; m_valid = 1'b1;
    end else if (m_left > 0) begin
      m_k++;
      m_left--;
      if (!(m_owner ? i.r1 : i.r0)) m_left = 0;
      if (m_left == 0) m_done_due = 1'b1;
    end else if (m_done_due) begin
      m_done_due = 1'b0;
    end else if (i.r0 || i.r1) begin
`ifdef DMA_ARB_RR_EN
      w = (i.r0 && i.r1) ? !m_last : i.r1;
`else
      w = !i.r0;
`endif
      m_owner = w;
      m_last  = w;
      m_rw    = w ? i.rw1 : i.rw0;
      m_base  = w ? i.a1 : i.a0;
      m_left  = int'(w ? i.l1 : i.l0);
      m_k     = 0;
      m_done_due = (m_left == 0);
    end
  endtask

  task automatic check(string name, logic [38:0] act, logic [38:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got flags=%b addr=%h data=%h, want flags=%b addr=%h data=%h",
               name, act[38:32], act[31:16], act[15:0], exp[38:32], exp[31:16], exp[15:0]);
    end
  endtask

  task automatic check_int(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  // One cycle: drive at the falling edge, compare against the model, then advance the model at the rising edge.
  task automatic cyc(in_t i, output logic [38:0] act);
    reset = i.rst; req0 = i.r0; req1 = i.r1; rw0 = i.rw0; rw1 = i.rw1;
    addr0 = i.a0; addr1 = i.a1; len0 = i.l0; len1 = i.l1; wdata0 = i.w0; wdata1 = i.w1;
    #1;
    act = {beat0, beat1, done0, done1, dma_enable, dma_rw, busy, dma_address, dma_input_data};
    if (m_valid) check($sformatf("model t=%0t", $time), act, model_out(i));
    @(posedge clk);
    model_step(i);
    @(negedge clk);
  endtask

  initial begin
    vec_t        tbl[$];
    in_t         idle, rst_in, t;
    logic [38:0] act;
    int          grants[4];
    int          exp_g[4];
    int          nbeats, ndone, gi;

    idle   = inp(0, 0, 0, 0, 16'h0, 16'h0, 8'd0, 8'd0, 16'h0, 16'h0);
    rst_in = idle;
    rst_in.rst = 1'b1;
    reset = 1'b1; req0 = 0; req1 = 0; rw0 = 0; rw1 = 0;
    addr0 = 0; addr1 = 0; len0 = 0; len1 = 0; wdata0 = 0; wdata1 = 0;
    @(negedge clk);
    cyc(rst_in, act);
    cyc(rst_in, act);
    cyc(idle, act);
    check("reset_idle", act, 39'h0);

    // Read burst at 0x0010, write burst wrapping past 0xFFFF, and a zero-length burst.
    t = inp(1, 0, 1, 0, 16'h0010, 16'h0, 8'd3, 8'd0, 16'h0, 16'h0);
    tbl.push_back(mkv(t, 7'b0000000, 16'h0000, 16'h0000));
    tbl.push_back(mkv(t, 7'b1000111, 16'h0010, 16'h0000));
    tbl.push_back(mkv(t, 7'b1000111, 16'h0011, 16'h0000));
    tbl.push_back(mkv(t, 7'b1000111, 16'h0012, 16'h0000));
    tbl.push_back(mkv(idle, 7'b0010001, 16'h0000, 16'h0000));
    tbl.push_back(mkv(idle, 7'b0000000, 16'h0000, 16'h0000));
    tbl.push_back(mkv(inp(0, 1, 0, 0, 16'h0, 16'hFFFE, 8'd0, 8'd4, 16'h0, 16'h0), 7'b0000000, 16'h0000, 16'h0000));
    tbl.push_back(mkv(inp(0, 1, 0, 0, 16'h0, 16'hFFFE, 8'd0, 8'd4, 16'h0, 16'h00A0), 7'b0100101, 16'hFFFE, 16'h00A0));
    tbl.push_back(mkv(inp(0, 1, 0, 0, 16'h0, 16'hFFFE, 8'd0, 8'd4, 16'h0, 16'h00A1), 7'b0100101, 16'hFFFF, 16'h00A1));
    tbl.push_back(mkv(inp(0, 1, 0, 0, 16'h0, 16'hFFFE, 8'd0, 8'd4, 16'h0, 16'h00A2), 7'b0100101, 16'h0000, 16'h00A2));
    tbl.push_back(mkv(inp(0, 1, 0, 0, 16'h0, 16'hFFFE, 8'd0, 8'd4, 16'h0, 16'h00A3), 7'b0100101, 16'h0001, 16'h00A3));
    tbl.push_back(mkv(idle, 7'b0001001, 16'h0000, 16'h0000));
    tbl.push_back(mkv(idle, 7'b0000000, 16'h0000, 16'h0000));
    tbl.push_back(mkv(inp(1, 0, 0, 0, 16'h0040, 16'h0, 8'd0, 8'd0, 16'h0, 16'h0), 7'b0000000, 16'h0000, 16'h0000));
    tbl.push_back(mkv(idle, 7'b0010001, 16'h0000, 16'h0000));
    tbl.push_back(mkv(idle, 7'b0000000, 16'h0000, 16'h0000));
    foreach (tbl[k]) begin
      cyc(tbl[k].i, act);
      check($sformatf("vec[%0d]", k), act, {tbl[k].flags, tbl[k].addr, tbl[k].data});
    end

    // Both requesters held high with length 2: grant order after reset.
    cyc(rst_in, act);
    t = inp(1, 1, 1, 0, 16'h1000, 16'h2000, 8'd2, 8'd2, 16'h0, 16'h0);
    gi = 0;
    for (int c = 0; c < 16; c++) begin
      cyc(t, act);
      if ((c % 4) == 1) begin
        grants[gi] = act[37] ? 1 : (act[38] ? 0 : -1);
        gi++;
      end
    end
`ifdef DMA_ARB_RR_EN
    exp_g = '{0, 1, 0, 1};
`else
    exp_g = '{0, 0, 0, 0};
`endif
    for (int k = 0; k < 4; k++) check_int($sformatf("grant[%0d]", k), grants[k], exp_g[k]);
    t = idle;
    cyc(t, act);
    cyc(t, act);

    // Early termination: len 8, request dropped after the third beat.
    nbeats = 0; ndone = 0;
    t = inp(1, 0, 0, 0, 16'h0300, 16'h0, 8'd8, 8'd0, 16'h0, 16'h0);
    for (int c = 0; c < 12; c++) begin
      if (c == 4) t.r0 = 1'b0;
      cyc(t, act);
      if (act[38]) nbeats++;
      if (act[36]) begin
        ndone++;
        check_int("early_done_cycle", c, 5);
      end
    end
    check_int("early_beats", nbeats, 4);
    check_int("early_dones", ndone, 1);

    // Reset during the second beat of a length-5 burst, then a normal burst from requester 1.
    t = inp(1, 0, 1, 0, 16'h0500, 16'h0, 8'd5, 8'd0, 16'h0, 16'h0);
    cyc(t, act);
    cyc(t, act);
    t.rst = 1'b1;
    cyc(t, act);
    check("abort_beat2", act, {7'b1000111, 16'h0501, 16'h0000});
    cyc(idle, act);
    check_int("abort_en", int'(act[34]), 0);
    check_int("abort_done", int'(act[36]), 0);
    t = inp(0, 1, 0, 0, 16'h0, 16'h0200, 8'd0, 8'd2, 16'h0, 16'h0055);
    cyc(t, act);
    cyc(t, act);
    check("after_abort_beat", act, {7'b0100101, 16'h0200, 16'h0055});
    cyc(t, act);
    cyc(idle, act);
    check("after_abort_done", act, {7'b0001001, 16'h0000, 16'h0000});
    cyc(idle, act);

    // Random traffic against the model.
    for (int c = 0; c < 600; c++) begin
      t.rst = ($urandom_range(0, 60) == 0);
      t.r0  = ($urandom_range(0, 3) != 0);
      t.r1  = ($urandom_range(0, 2) != 0);
      t.rw0 = 1'($urandom_range(0, 1));
      t.rw1 = 1'($urandom_range(0, 1));
      t.a0  = 16'($urandom);
      t.a1  = 16'($urandom);
      t.l0  = 8'($urandom_range(0, 5));
      t.l1  = 8'($urandom_range(0, 5));
      t.w0  = 16'($urandom);
      t.w1  = 16'($urandom);
      cyc(t, act);
      n_cmp++;
      if ((act[38] && act[37]) || (act[36] && act[35])) begin
        n_bad++;
        $display("FAIL exclusive t=%0t: flags=%b", $time, act[38:32]);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
